// File: rtl/vdp_pkg.sv
// rtl/vdp_pkg.sv - shared encodings and bit positions for the VDP CPU port
package vdp_pkg;

   localparam logic [7:0] PORT_DATA = 8'hBE;
   localparam logic [7:0] PORT_CTRL = 8'hBF;

   typedef enum logic {
      LATCH_FIRST  = 1'b0,
      LATCH_SECOND = 1'b1
   } latch_state_t;

   typedef enum logic [1:0] {
      VRAM_IDLE = 2'd0,
      VRAM_WR   = 2'd1,
      VRAM_RD   = 2'd2
   } vram_state_t;

   localparam int STAT_F  = 7;
   localparam int STAT_5S = 6;
   localparam int STAT_C  = 5;

   localparam int R1_BLANK = 6;
   localparam int R1_IE    = 5;

endpackage

// File: rtl/vdp_status_reg.sv
// rtl/vdp_status_reg.sv - VDP status flags F/5S/C and the frozen fifth-sprite number
module vdp_status_reg
   import vdp_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_ev_frame,
   input  logic       i_ev_coll,
   input  logic       i_ev_fifth,
   input  logic [4:0] i_ev_fifth_num,
   input  logic       i_clr,
   output logic [7:0] o_status,
   output logic       o_flag_f
);

   logic       r_f;
   logic       r_5s;
   logic       r_c;
   logic [4:0] r_fifth_num;

   // An event arriving in the same cycle as a status read wins over the clear.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_f         <= 1'b0;
         r_5s        <= 1'b0;
         r_c         <= 1'b0;
         r_fifth_num <= 5'h1F;
      end else begin
         r_f  <= i_ev_frame | (r_f & ~i_clr);
         r_c  <= i_ev_coll  | (r_c & ~i_clr);
         r_5s <= i_ev_fifth | (r_5s & ~i_clr);
         if (i_ev_fifth && !r_5s) begin
            r_fifth_num <= i_ev_fifth_num;
         end
      end
   end

   always_comb begin
      o_status          = {3'b000, r_fifth_num};
      o_status[STAT_F]  = r_f;
      o_status[STAT_5S] = r_5s;
      o_status[STAT_C]  = r_c;
   end

   assign o_flag_f = r_f;

endmodule

// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - Z80 I/O front end of the VDP: control latch, registers,
// VRAM pointer, read-ahead buffer, VRAM request port and frame interrupt
module vdp_cpu_port
   import vdp_pkg::*;
#(
   parameter int ADDR_W   = 14,
   parameter int NUM_REGS = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_clk_en,
   input  logic                  i_io_wr,
   input  logic                  i_io_rd,
   input  logic                  i_port_ctrl,
   input  logic [7:0]            i_cpu_din,
   output logic [7:0]            o_cpu_dout,
   output logic                  o_wait_n,
   output logic [ADDR_W-1:0]     o_vram_addr,
   output logic [7:0]            o_vram_wdata,
   output logic                  o_vram_we,
   output logic                  o_vram_re,
   input  logic [7:0]            i_vram_rdata,
   input  logic                  i_vram_ack,
   input  logic                  i_ev_frame,
   input  logic                  i_ev_coll,
   input  logic                  i_ev_fifth,
   input  logic [4:0]            i_ev_fifth_num,
   output logic [8*NUM_REGS-1:0] o_regs_out,
   output logic                  o_int_n
);

   logic                r_prev;
   latch_state_t        r_lstate;
   latch_state_t        w_lstate_nx;
   vram_state_t         r_vstate;
   vram_state_t         w_vstate_nx;
   logic [7:0]          r_latch;
   logic [7:0]          r_regs [NUM_REGS];
   logic [ADDR_W-1:0]   r_ptr;
   logic [7:0]          r_ra;
   logic [ADDR_W-1:0]   r_vaddr;
   logic [7:0]          r_vwdata;

   logic                r_pend;
   logic                r_pend_ctrl;
   logic                r_pend_wr;
   logic [7:0]          r_pend_din;

   logic                w_req;
   logic                w_start;
   logic                w_busy;
   logic                w_live_need;
   logic                w_hold;
   logic                w_exec;
   logic                w_op_ctrl;
   logic                w_op_wr;
   logic [7:0]          w_op_din;
   logic                w_do_dwr;
   logic                w_do_drd;
   logic                w_do_cwr;
   logic                w_do_crd;
   logic                w_cwr_second;
   logic                w_do_reg;
   logic                w_do_ptr;
   logic                w_do_pf;
   logic                w_issue;
   logic [ADDR_W-1:0]   w_new_ptr;
   logic [ADDR_W-1:0]   w_req_addr;
   logic [7:0]          w_status;
   logic                w_flag_f;

   assign w_req   = i_io_wr | i_io_rd;
   assign w_start = i_clk_en & w_req & ~r_prev;
   assign w_busy  = (r_vstate != VRAM_IDLE);

   // Only accesses that need the VRAM port can be held off by a busy port.
   assign w_live_need = ~i_port_ctrl
                      | (i_io_wr & (r_lstate == LATCH_SECOND) & (i_cpu_din[7:6] == 2'b00));
   assign w_hold      = w_start & w_live_need & w_busy;
   assign w_exec      = r_pend ? ~w_busy : (w_start & ~w_hold);

   assign w_op_ctrl = r_pend ? r_pend_ctrl : i_port_ctrl;
   assign w_op_wr   = r_pend ? r_pend_wr   : i_io_wr;
   assign w_op_din  = r_pend ? r_pend_din  : i_cpu_din;

   assign w_do_dwr     = w_exec & ~w_op_ctrl &  w_op_wr;
   assign w_do_drd     = w_exec & ~w_op_ctrl & ~w_op_wr;
   assign w_do_cwr     = w_exec &  w_op_ctrl &  w_op_wr;
   assign w_do_crd     = w_exec &  w_op_ctrl & ~w_op_wr;
   assign w_cwr_second = w_do_cwr & (r_lstate == LATCH_SECOND);
   assign w_do_reg     = w_cwr_second &  w_op_din[7];
   assign w_do_ptr     = w_cwr_second & ~w_op_din[7];
   assign w_do_pf      = w_do_drd | (w_do_ptr & ~w_op_din[6]);
   assign w_issue      = w_do_dwr | w_do_pf;

   assign w_new_ptr  = ADDR_W'({w_op_din[5:0], r_latch});
   assign w_req_addr = w_do_ptr ? w_new_ptr : r_ptr;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_prev <= 1'b0;
      end else if (i_clk_en) begin
         r_prev <= w_req;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pend      <= 1'b0;
         r_pend_ctrl <= 1'b0;
         r_pend_wr   <= 1'b0;
         r_pend_din  <= 8'h00;
      end else if (w_hold) begin
         r_pend      <= 1'b1;
         r_pend_ctrl <= i_port_ctrl;
         r_pend_wr   <= i_io_wr;
         r_pend_din  <= i_cpu_din;
      end else if (r_pend && !w_busy) begin
         r_pend      <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_lstate <= LATCH_FIRST;
      end else begin
         r_lstate <= w_lstate_nx;
      end
   end

   always_comb begin
      w_lstate_nx = r_lstate;
      if (w_do_cwr) begin
         w_lstate_nx = (r_lstate == LATCH_FIRST) ? LATCH_SECOND : LATCH_FIRST;
      end else if (w_do_dwr || w_do_drd || w_do_crd) begin
         w_lstate_nx = LATCH_FIRST;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_latch <= 8'h00;
         r_ptr   <= '0;
         r_ra    <= 8'h00;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= 8'h00;
         end
      end else begin
         if (w_do_cwr && (r_lstate == LATCH_FIRST)) begin
            r_latch <= w_op_din;
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_do_reg && (w_op_din[5:0] == 6'(i))) begin
               r_regs[i] <= r_latch;
            end
         end
         if (w_do_dwr || w_do_drd) begin
            r_ptr <= r_ptr + ADDR_W'(1);
         end else if (w_do_ptr) begin
            r_ptr <= w_op_din[6] ? w_new_ptr : w_new_ptr + ADDR_W'(1);
         end
         if (w_do_dwr) begin
            r_ra <= w_op_din;
         end else if ((r_vstate == VRAM_RD) && i_vram_ack) begin
            r_ra <= i_vram_rdata;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_vstate <= VRAM_IDLE;
         r_vaddr  <= '0;
         r_vwdata <= 8'h00;
      end else begin
         r_vstate <= w_vstate_nx;
         if ((r_vstate == VRAM_IDLE) && w_issue) begin
            r_vaddr  <= w_req_addr;
            r_vwdata <= w_op_din;
         end
      end
   end

   always_comb begin
      w_vstate_nx = r_vstate;
      case (r_vstate)
         VRAM_IDLE: begin
            if (w_do_dwr) begin
               w_vstate_nx = VRAM_WR;
            end else if (w_do_pf) begin
               w_vstate_nx = VRAM_RD;
            end
         end
         VRAM_WR, VRAM_RD: begin
            if (i_vram_ack) begin
               w_vstate_nx = VRAM_IDLE;
            end
         end
         default: w_vstate_nx = VRAM_IDLE;
      endcase
   end

   always_comb begin
      o_vram_we    = (r_vstate == VRAM_WR);
      o_vram_re    = (r_vstate == VRAM_RD);
      o_vram_addr  = r_vaddr;
      o_vram_wdata = r_vwdata;
   end

   vdp_status_reg u_status (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_ev_frame     (i_ev_frame),
      .i_ev_coll      (i_ev_coll),
      .i_ev_fifth     (i_ev_fifth),
      .i_ev_fifth_num (i_ev_fifth_num),
      .i_clr          (w_do_crd),
      .o_status       (w_status),
      .o_flag_f       (w_flag_f)
   );

   // A held access releases WAIT in the very cycle it is finally accepted.
   assign o_wait_n   = ~((r_pend & w_busy) | w_hold);
   assign o_cpu_dout = i_port_ctrl ? w_status : r_ra;
   assign o_int_n    = ~(w_flag_f & r_regs[1][R1_IE]);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
      assign o_regs_out[g*8 +: 8] = r_regs[g];
   end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb/tb_vdp_cpu_port.sv - directed bench for vdp_cpu_port with a latency-programmable VRAM responder
module tb_vdp_cpu_port;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clk_en;
   logic        io_wr;
   logic        io_rd;
   logic        port_ctrl;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        wait_n;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        vram_we;
   logic        vram_re;
   logic [7:0]  vram_rdata;
   logic        vram_ack;
   logic        ev_frame;
   logic        ev_coll;
   logic        ev_fifth;
   logic [4:0]  ev_fifth_num;
   logic [63:0] regs_out;
   logic        int_n;

   always #5 clk = ~clk;

   vdp_cpu_port #(.ADDR_W(14), .NUM_REGS(8)) dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_clk_en       (clk_en),
      .i_io_wr        (io_wr),
      .i_io_rd        (io_rd),
      .i_port_ctrl    (port_ctrl),
      .i_cpu_din      (cpu_din),
      .o_cpu_dout     (cpu_dout),
      .o_wait_n       (wait_n),
      .o_vram_addr    (vram_addr),
      .o_vram_wdata   (vram_wdata),
      .o_vram_we      (vram_we),
      .o_vram_re      (vram_re),
      .i_vram_rdata   (vram_rdata),
      .i_vram_ack     (vram_ack),
      .i_ev_frame     (ev_frame),
      .i_ev_coll      (ev_coll),
      .i_ev_fifth     (ev_fifth),
      .i_ev_fifth_num (ev_fifth_num),
      .o_regs_out     (regs_out),
      .o_int_n        (int_n)
   );

   logic [7:0]  mem [0:16383];
   int          lat = 0;
   int          cnt = 0;
   int          wr_count = 0;
   int          rd_count = 0;
   int          stab_err = 0;
   logic [13:0] last_waddr = '0;
   logic [7:0]  last_wdata = '0;
   logic        req_seen = 1'b0;
   logic [13:0] req_addr0 = '0;
   logic [7:0]  req_data0 = '0;
   logic        frame_with_acc = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   // VRAM responder: acks after lat+1 cycles of request, checks request stability
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vram_ack   <= 1'b0;
         vram_rdata <= 8'h00;
         cnt        <= 0;
         req_seen   <= 1'b0;
      end else if (vram_ack) begin
         vram_ack <= 1'b0;
         req_seen <= 1'b0;
      end else if (vram_we || vram_re) begin
         if (!req_seen) begin
            req_seen  <= 1'b1;
            req_addr0 <= vram_addr;
            req_data0 <= vram_wdata;
         end else if (vram_addr != req_addr0 || (vram_we && vram_wdata != req_data0)) begin
            stab_err <= stab_err + 1;
         end
         if (cnt >= lat) begin
            vram_ack   <= 1'b1;
            vram_rdata <= mem[vram_addr];
            cnt        <= 0;
            if (vram_we) begin
               wr_count   <= wr_count + 1;
               last_waddr <= vram_addr;
               last_wdata <= vram_wdata;
            end else begin
               rd_count <= rd_count + 1;
            end
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_access(input bit ctrl, input bit wr, input logic [7:0] din,
                             output logic [7:0] dout, output int waits);
      @(negedge clk);
      port_ctrl = ctrl;
      io_wr     = wr;
      io_rd     = ~wr;
      cpu_din   = din;
      ev_frame  = frame_with_acc;
      #1;
      waits = 0;
      while (!wait_n && waits < 200) begin
         @(negedge clk);
         ev_frame = 1'b0;
         #1;
         waits++;
      end
      check_eq("wait_bound", waits >= 200, 0);
      dout = cpu_dout;
      @(negedge clk);
      io_wr    = 1'b0;
      io_rd    = 1'b0;
      ev_frame = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while ((vram_we || vram_re || vram_ack) && k < 500) begin
         @(negedge clk);
         k++;
      end
      check_eq("idle_bound", k >= 500, 0);
      @(negedge clk);
   endtask

   task automatic pulse(input int which, input logic [4:0] num);
      @(negedge clk);
      ev_frame     = (which == 0);
      ev_coll      = (which == 1);
      ev_fifth     = (which == 2);
      ev_fifth_num = num;
      @(negedge clk);
      ev_frame = 1'b0;
      ev_coll  = 1'b0;
      ev_fifth = 1'b0;
   endtask

   logic [7:0] d;
   int         w;
   int         wc0;
   int         rc0;

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'(i * 7 + 3);
      mem[0] = 8'h5A;
      mem[1] = 8'hC3;
      reset_n = 1'b0; clk_en = 1'b1; io_wr = 1'b0; io_rd = 1'b0; port_ctrl = 1'b0;
      cpu_din = 8'h00; ev_frame = 1'b0; ev_coll = 1'b0; ev_fifth = 1'b0; ev_fifth_num = 5'h00;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // reset state
      check_eq("rst_we", vram_we, 0);
      check_eq("rst_re", vram_re, 0);
      check_eq("rst_wait_n", wait_n, 1);
      check_eq("rst_int_n", int_n, 1);
      check_eq("rst_regs", regs_out, 64'h0);
      port_ctrl = 1'b1; #1;
      check_eq("rst_status", cpu_dout, 8'h1F);
      port_ctrl = 1'b0; #1;
      check_eq("rst_readahead", cpu_dout, 8'h00);

      // 1: pointer load without prefetch, then data writes
      wc0 = wr_count; rc0 = rd_count;
      cpu_access(1, 1, 8'h34, d, w);
      cpu_access(1, 1, 8'h41, d, w);
      wait_idle();
      check_eq("t1_no_req_wr", wr_count - wc0, 0);
      check_eq("t1_no_req_rd", rd_count - rc0, 0);
      cpu_access(0, 1, 8'hAA, d, w);
      wait_idle();
      check_eq("t1_waddr", last_waddr, 14'h0134);
      check_eq("t1_wdata", last_wdata, 8'hAA);
      cpu_access(0, 1, 8'hBB, d, w);
      wait_idle();
      check_eq("t1_ptr_inc", last_waddr, 14'h0135);
      check_eq("t1_wcount", wr_count - wc0, 2);

      // 2: register writes, out-of-range index ignored
      cpu_access(1, 1, 8'h07, d, w);
      cpu_access(1, 1, 8'h81, d, w);
      check_eq("t2_r1", regs_out[15:8], 8'h07);
      cpu_access(1, 1, 8'h55, d, w);
      cpu_access(1, 1, 8'h88, d, w);
      check_eq("t2_idx8_ignored", regs_out, 64'h0000_0000_0000_0700);

      // 3: prefetching pointer load, then two data reads
      cpu_access(1, 1, 8'h00, d, w);
      cpu_access(1, 1, 8'h00, d, w);
      wait_idle();
      cpu_access(0, 0, 8'h00, d, w);
      check_eq("t3_read0", d, 8'h5A);
      wait_idle();
      cpu_access(0, 0, 8'h00, d, w);
      check_eq("t3_read1", d, 8'hC3);
      wait_idle();

      // 4: status read resets the latch FSM
      cpu_access(1, 1, 8'h12, d, w);
      cpu_access(1, 0, 8'h00, d, w);
      cpu_access(1, 1, 8'h10, d, w);
      cpu_access(1, 1, 8'h40, d, w);
      cpu_access(0, 1, 8'h5C, d, w);
      wait_idle();
      check_eq("t4_ptr", last_waddr, 14'h0010);

      // 5: frame interrupt and status flags
      cpu_access(1, 1, 8'h20, d, w);
      cpu_access(1, 1, 8'h81, d, w);
      @(negedge clk);
      ev_frame = 1'b1; #1;
      check_eq("t5_int_before", int_n, 1);
      @(negedge clk);
      ev_frame = 1'b0; #1;
      check_eq("t5_int_after", int_n, 0);
      cpu_access(1, 0, 8'h00, d, w);
      check_eq("t5_status_f", d, 8'h9F);
      #1;
      check_eq("t5_int_cleared", int_n, 1);
      pulse(2, 5'h03);
      pulse(2, 5'h07);
      cpu_access(1, 0, 8'h00, d, w);
      check_eq("t5_fifth_frozen", d, 8'h43);
      pulse(1, 5'h00);
      frame_with_acc = 1'b1;
      cpu_access(1, 0, 8'h00, d, w);
      frame_with_acc = 1'b0;
      check_eq("t5_status_c", d, 8'h23);
      #1;
      check_eq("t5_set_wins_int", int_n, 0);
      cpu_access(1, 0, 8'h00, d, w);
      check_eq("t5_set_wins_f", d, 8'h83);

      // 6: busy contention with slow acks, then pointer wrap
      cpu_access(1, 1, 8'h00, d, w);
      cpu_access(1, 1, 8'h41, d, w);
      lat = 20;
      wc0 = wr_count;
      cpu_access(0, 1, 8'h11, d, w);
      check_eq("t6_first_no_wait", w, 0);
      cpu_access(0, 1, 8'h22, d, w);
      check_eq("t6_second_waited", w > 10, 1);
      check_eq("t6_first_done_in_wait", wr_count - wc0, 1);
      wait_idle();
      check_eq("t6_wcount", wr_count - wc0, 2);
      check_eq("t6_waddr2", last_waddr, 14'h0101);
      check_eq("t6_wdata2", last_wdata, 8'h22);
      lat = 0;
      cpu_access(0, 1, 8'h33, d, w);
      wait_idle();
      check_eq("t6_ptr_plus2", last_waddr, 14'h0102);
      cpu_access(1, 1, 8'hFF, d, w);
      cpu_access(1, 1, 8'h7F, d, w);
      cpu_access(0, 1, 8'h77, d, w);
      wait_idle();
      check_eq("t6_top_addr", last_waddr, 14'h3FFF);
      cpu_access(0, 1, 8'h78, d, w);
      wait_idle();
      check_eq("t6_wrap", last_waddr, 14'h0000);
      check_eq("req_stable", stab_err, 0);

      // asynchronous reset drops an outstanding request at once
      lat = 20;
      cpu_access(0, 1, 8'h99, d, w);
      @(negedge clk);
      check_eq("rst_mid_req_up", vram_we, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("rst_mid_we", vram_we, 0);
      check_eq("rst_mid_regs", regs_out, 64'h0);
      check_eq("rst_mid_int_n", int_n, 1);
      @(negedge clk);
      reset_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
